// File: rtl/player_state_controller.sv
// player_state_controller: sequences one updater request per frame and commits its result; PLAYER_TIMEOUT_EN adds a watchdog on the updater wait.
module player_state_controller #(
  parameter logic [13:0] START_X        = 14'd384,
  parameter logic [12:0] START_Y        = 13'd384,
  parameter logic [7:0]  START_ANGLE    = 8'd0,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        frame_tick_i,
  output logic        upd_start_o,
  input  logic        upd_done_i,
  input  logic [13:0] next_pos_x_i,
  input  logic [12:0] next_pos_y_i,
  input  logic [7:0]  next_angle_i,
  output logic [13:0] cur_pos_x_o,
  output logic [12:0] cur_pos_y_o,
  output logic [7:0]  cur_angle_o,
  output logic        pos_valid_o,
  output logic        overrun_o,
  output logic        timeout_o,
  output logic [15:0] frame_count_o
);
  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;
  state_t      state_q;
  logic [13:0] x_q;
  logic [12:0] y_q;
  logic [7:0]  a_q;
  logic [15:0] fc_q;
  logic        ovr_q;
`ifdef PLAYER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;
  logic            to_q;
  assign timeout_o = to_q;
`else
  assign timeout_o = 1'b0;
`endif
  assign upd_start_o   = state_q == START;
  assign pos_valid_o   = state_q == IDLE;
  assign cur_pos_x_o   = x_q;
  assign cur_pos_y_o   = y_q;
  assign cur_angle_o   = a_q;
  assign overrun_o     = ovr_q;
  assign frame_count_o = fc_q;
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      x_q     <= START_X;
      y_q     <= START_Y;
      a_q     <= START_ANGLE;
      fc_q    <= '0;
      ovr_q   <= 1'b0;
`ifdef PLAYER_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      // a tick seen anywhere but IDLE is dropped, never queued
      if (frame_tick_i && state_q != IDLE) ovr_q <= 1'b1;
      case (state_q)
        IDLE: if (frame_tick_i) state_q <= START;
        START: begin
          state_q <= WAIT;
`ifdef PLAYER_TIMEOUT_EN
          wd_q    <= '0;
`endif
        end
        WAIT: begin
          if (upd_done_i) begin
            x_q     <= next_pos_x_i;
            y_q     <= next_pos_y_i;
            a_q     <= next_angle_i;
            fc_q    <= fc_q + 16'd1;
            state_q <= IDLE;
          end
`ifdef PLAYER_TIMEOUT_EN
          // commit above takes priority over expiry on the same cycle
          else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
            state_q <= IDLE;
            to_q    <= 1'b1;
          end else wd_q <= wd_q + 1'b1;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_player_state_controller.sv
// tb_player_state_controller: table-driven vectors plus hand sequences for reset abort, watchdog and count wrap.
module tb_player_state_controller;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        done = 1'b0;
  logic [13:0] nx = '0;
  logic [12:0] ny = '0;
  logic [7:0]  na = '0;
  logic        start, valid, ovr, tmo;
  logic [13:0] cx;
  logic [12:0] cy;
  logic [7:0]  ca;
  logic [15:0] fc;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  player_state_controller #(.TIMEOUT_CYCLES(8)) dut (
    .clock_i(clk), .reset_i(rst_n), .frame_tick_i(tick), .upd_start_o(start),
    .upd_done_i(done), .next_pos_x_i(nx), .next_pos_y_i(ny), .next_angle_i(na),
    .cur_pos_x_o(cx), .cur_pos_y_o(cy), .cur_angle_o(ca), .pos_valid_o(valid),
    .overrun_o(ovr), .timeout_o(tmo), .frame_count_o(fc)
  );

  typedef struct {
    logic        tick, done;
    logic [13:0] nx;
    logic [12:0] ny;
    logic [7:0]  na;
    logic        start, valid;
    logic [13:0] x;
    logic [12:0] y;
    logic [7:0]  a;
    logic [15:0] fc;
    logic        ovr;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cur(input string n, input logic [13:0] x, input logic [12:0] y, input logic [7:0] a);
    chk({n, " x"}, 32'(cx), 32'(x));
    chk({n, " y"}, 32'(cy), 32'(y));
    chk({n, " angle"}, 32'(ca), 32'(a));
  endtask

  task automatic do_reset();
    tick = 0; done = 0; rst_n = 0;
    cyc();
    rst_n = 1;
  endtask

  initial begin
    // tick, done 3 cycles after start; then overrun with ticks in START, WAIT and commit cycle
    tbl[0]  = '{1, 0, 0,   0,   0,     1, 0, 384, 384, 0,     0, 0};
    tbl[1]  = '{0, 0, 0,   0,   0,     0, 0, 384, 384, 0,     0, 0};
    tbl[2]  = '{0, 1, 0,   0,   0,     0, 0, 384, 384, 0,     0, 0};
    tbl[3]  = '{0, 0, 0,   0,   0,     0, 0, 384, 384, 0,     0, 0};
    tbl[4]  = '{0, 1, 500, 600, 8'h40, 0, 1, 500, 600, 8'h40, 1, 0};
    tbl[5]  = '{1, 0, 0,   0,   0,     1, 0, 500, 600, 8'h40, 1, 0};
    tbl[6]  = '{1, 0, 0,   0,   0,     0, 0, 500, 600, 8'h40, 1, 1};
    tbl[7]  = '{1, 0, 0,   0,   0,     0, 0, 500, 600, 8'h40, 1, 1};
    tbl[8]  = '{1, 1, 700, 800, 8'h80, 0, 1, 700, 800, 8'h80, 2, 1};
    tbl[9]  = '{0, 0, 0,   0,   0,     0, 1, 700, 800, 8'h80, 2, 1};
    tbl[10] = '{0, 1, 1,   2,   3,     0, 1, 700, 800, 8'h80, 2, 1};
    tbl[2].done = 0;

    do_reset();
    chk_cur("reset", 384, 384, 0);
    chk("reset valid", 32'(valid), 1);
    chk("reset start", 32'(start), 0);
    chk("reset fc", 32'(fc), 0);
    chk("reset ovr", 32'(ovr), 0);
    chk("reset tmo", 32'(tmo), 0);

    for (int i = 0; i < 11; i++) begin
      tick = tbl[i].tick; done = tbl[i].done;
      nx = tbl[i].nx; ny = tbl[i].ny; na = tbl[i].na;
      cyc();
      chk($sformatf("v%0d start", i), 32'(start), 32'(tbl[i].start));
      chk($sformatf("v%0d valid", i), 32'(valid), 32'(tbl[i].valid));
      chk_cur($sformatf("v%0d", i), tbl[i].x, tbl[i].y, tbl[i].a);
      chk($sformatf("v%0d fc", i), 32'(fc), 32'(tbl[i].fc));
      chk($sformatf("v%0d ovr", i), 32'(ovr), 32'(tbl[i].ovr));
      chk($sformatf("v%0d tmo", i), 32'(tmo), 0);
    end
    tick = 0; done = 0;

    // watchdog expiry with no done
    do_reset();
    tick = 1; cyc(); tick = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk($sformatf("wd wait%0d valid", i), 32'(valid), 0);
    end
    cyc();
`ifdef PLAYER_TIMEOUT_EN
    chk("wd expire valid", 32'(valid), 1);
    chk("wd expire tmo", 32'(tmo), 1);
    chk("wd expire fc", 32'(fc), 0);
    chk_cur("wd expire", 384, 384, 0);
    // done on the exact expiry cycle: commit wins
    do_reset();
    tick = 1; cyc(); tick = 0;
    for (int i = 0; i < 8; i++) cyc();
    done = 1; nx = 11; ny = 22; na = 33;
    cyc();
    done = 0;
    chk("wd tie valid", 32'(valid), 1);
    chk("wd tie tmo", 32'(tmo), 0);
    chk("wd tie fc", 32'(fc), 1);
    chk_cur("wd tie", 11, 22, 33);
`else
    for (int i = 0; i < 12; i++) cyc();
    chk("no wd valid", 32'(valid), 0);
    chk("no wd tmo", 32'(tmo), 0);
    done = 1; nx = 11; ny = 22; na = 33;
    cyc();
    done = 0;
    chk("no wd commit valid", 32'(valid), 1);
    chk("no wd commit fc", 32'(fc), 1);
    chk_cur("no wd commit", 11, 22, 33);
`endif

    // reset mid-WAIT, then a late done in IDLE
    do_reset();
    tick = 1; cyc(); tick = 0; cyc(); cyc();
    chk("abort in wait", 32'(valid), 0);
    rst_n = 0; cyc(); rst_n = 1;
    chk("abort valid", 32'(valid), 1);
    done = 1; nx = 9; ny = 9; na = 9;
    cyc();
    done = 0;
    chk_cur("abort late done", 384, 384, 0);
    chk("abort fc", 32'(fc), 0);
    chk("abort valid2", 32'(valid), 1);

    // frame count wrap
    do_reset();
    force dut.fc_q = 16'hFFFF;
    cyc();
    release dut.fc_q;
    cyc();
    chk("wrap preload", 32'(fc), 32'hFFFF);
    tick = 1; cyc(); tick = 0; cyc();
    done = 1; nx = 100; ny = 200; na = 8'hFE;
    cyc();
    done = 0;
    chk("wrap fc", 32'(fc), 0);
    chk("wrap ovr", 32'(ovr), 0);
    chk("wrap tmo", 32'(tmo), 0);
    chk_cur("wrap", 100, 200, 8'hFE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/player_state_controller.md
PLAYER_STATE_CONTROLLER -- requirements
Module: player_state_controller

Interface
REQ-001 Parameter: START_X, default 14'd384, reset x position of the player (grid cell 1, centre).
REQ-002 Parameter: START_Y, default 13'd384, reset y position of the player.
REQ-003 Parameter: START_ANGLE, default 8'd0, reset view angle.
REQ-004 Parameter: TIMEOUT_CYCLES, default 1023, watchdog limit in clock cycles while waiting for the updater.
REQ-005 clock  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-006 reset  in  1  synchronous, active-low reset.
REQ-007 frame_tick  in  1  one-cycle pulse requesting one player update per frame.
REQ-008 upd_start  out  1  one-cycle start pulse to the player updater.
REQ-009 upd_done  in  1  updater completion; may be a pulse or a level.
REQ-010 next_pos_x  in  14  updater result, x position.
REQ-011 next_pos_y  in  13  updater result, y position.
REQ-012 next_angle  in  8  updater result, view angle.
REQ-013 cur_pos_x  out  14  committed x position, fed back to the updater and the renderer.
REQ-014 cur_pos_y  out  13  committed y position.
REQ-015 cur_angle  out  8  committed view angle.
REQ-016 pos_valid  out  1  high when the controller is in IDLE and cur_* are stable.
REQ-017 overrun  out  1  sticky flag: a frame_tick was dropped.
REQ-018 timeout  out  1  sticky flag: the watchdog expired.
REQ-019 frame_count  out  16  number of committed updates; wraps modulo 2^16.

Function
REQ-020 The FSM SHALL have the states IDLE, START and WAIT.
REQ-021 IDLE: frame_tick=1 -> START on the next edge; otherwise the FSM SHALL stay in IDLE.
REQ-022 START: upd_start SHALL be 1 for exactly this one cycle; the FSM SHALL go to WAIT on the next edge unconditionally.
REQ-023 upd_start SHALL be 0 in every state other than START.
REQ-024 WAIT, upd_done=1: on that edge the block SHALL load next_pos_x, next_pos_y and next_angle into cur_*, increment frame_count and return to IDLE.
REQ-025 cur_* SHALL change only on a commit (REQ-024) or on reset.
REQ-026 cur_* SHALL hold between commits so the updater sees stable inputs throughout an update.
REQ-027 Minimum latency: tick sampled at edge 0 -> upd_start high in cycle 1 -> done sampled at edge 2 or later -> cur_* valid the cycle after.
REQ-028 upd_done sampled in IDLE or START SHALL be ignored; it SHALL NOT cause a commit.
REQ-029 frame_tick sampled in START or WAIT, including the commit cycle, SHALL be dropped and SHALL set overrun; no request is queued.
REQ-030 pos_valid SHALL be 1 in IDLE and 0 in START and WAIT.
REQ-031 frame_count SHALL wrap from 16'hFFFF to 16'h0000 without setting any flag.
REQ-032 overrun and timeout SHALL clear only on reset.

Reset
REQ-033 reset=0 sampled on a rising edge SHALL set state=IDLE, upd_start=0, cur_pos_x=START_X, cur_pos_y=START_Y, cur_angle=START_ANGLE, frame_count=0, overrun=0, timeout=0 and watchdog=0.
REQ-034 Reset asserted in START or WAIT SHALL abort the update with no commit; an upd_done arriving later in IDLE SHALL be ignored per REQ-028.
REQ-035 pos_valid SHALL be 1 on the first cycle after reset.

Configuration
REQ-036 With PLAYER_TIMEOUT_EN defined, a counter SHALL clear on entry to WAIT and increment each cycle in WAIT.
REQ-037 With PLAYER_TIMEOUT_EN defined, when that counter reaches TIMEOUT_CYCLES without upd_done, the FSM SHALL go to IDLE with no commit and SHALL set timeout.
REQ-038 With PLAYER_TIMEOUT_EN defined, if upd_done arrives on the same cycle the counter reaches TIMEOUT_CYCLES, the commit SHALL win and timeout SHALL NOT be set.
REQ-039 Without PLAYER_TIMEOUT_EN, WAIT SHALL persist until upd_done, timeout SHALL be tied to 0, and no counter logic SHALL be built.

Verification
REQ-040 Reset release -> cur=(384,384,0), pos_valid=1, frame_count=0, overrun=0, timeout=0.
REQ-041 Tick, then done 3 cycles after upd_start with next=(500,600,8'h40) -> exactly one upd_start pulse; cur=(500,600,0x40) the cycle after done; frame_count=1.
REQ-042 Second tick while in WAIT -> no second upd_start; overrun=1; after done, frame_count=1 only.
REQ-043 Tick with done never asserted, TIMEOUT_CYCLES=8, macro defined -> IDLE after 8 WAIT cycles; timeout=1; cur unchanged.
REQ-044 Reset asserted mid-WAIT, then done pulsed in IDLE -> cur=start values; frame_count=0; no commit.
REQ-045 Preload frame_count to 16'hFFFF, then one full update -> frame_count=0; overrun=0 and timeout=0.
